// File: rtl/median_pkg.sv
// Shared types and constants for the 5-row column feeder.
// Pixel type, row/line-buffer counts and the line-fill counter helper.
package median_pkg;

    localparam int PIXEL_W     = 8;
    localparam int NUM_ROWS    = 5;
    localparam int NUM_LINEBUF = 4;
    localparam int FILL_W      = 3;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Line-fill counter advances once per completed line and stops at NUM_LINEBUF.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_W'(NUM_LINEBUF)) ? f : f + 1'b1;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer: one write port, one read port with a
// registered read (data appears the cycle after i_re). Contents are not reset.
module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int AW         = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Read register only loads on a read strobe so the output holds between reads.
    always_comb begin
        rdata_d = i_re ? mem[i_raddr] : rdata_q;
    end

    // Storage write and read register update.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/axis_column_feeder_5rows.sv
// AXI-Stream pixel sink that emits one vertical 5-pixel column per accepted
// beat, using 4 line buffers shifted down one line per beat.
// Optional build macro: COLUMN_FEEDER_BORDER_REPLICATE_EN -- rows not yet
// filled in the current frame replicate the oldest valid row instead of zero.
module axis_column_feeder_5rows
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
    input  logic                  i_s_axis_tvalid,
    output logic                  o_s_axis_tready,
    input  logic                  i_s_axis_tuser,
    input  logic                  i_s_axis_tlast,
    output logic [DATA_WIDTH-1:0] o_col_0,
    output logic [DATA_WIDTH-1:0] o_col_1,
    output logic [DATA_WIDTH-1:0] o_col_2,
    output logic [DATA_WIDTH-1:0] o_col_3,
    output logic [DATA_WIDTH-1:0] o_col_4,
    output logic                  o_col_valid,
    output logic                  o_col_sof,
    output logic                  o_col_eol,
    output logic                  o_rows_full,
    output logic                  o_err_eol
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);

`ifdef COLUMN_FEEDER_BORDER_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    logic                  tready_q, tready_d;
    logic [AW-1:0]         col_q, col_d, col_eff;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_eff;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [FILL_W-1:0]     ofill_q, ofill_d;
    logic                  sof_q, sof_d;
    logic                  eol_q, eol_d;
    logic                  err_q, err_d;
    logic                  byp_q, byp_d;

    logic [NUM_LINEBUF-1:0][DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [NUM_LINEBUF-1:0][DATA_WIDTH-1:0] ram_rd, eff_rd, ram_wd;
    logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]    raw_col, out_col;

    logic accept, at_last, line_end, err_now;

    assign accept = i_s_axis_tvalid & tready_q;

    // Frame restart and line-end decode for the beat currently presented.
    always_comb begin
        col_eff  = i_s_axis_tuser ? '0 : col_q;
        fill_eff = i_s_axis_tuser ? '0 : fill_q;
        at_last  = (col_eff == COL_LAST);
        line_end = i_s_axis_tlast | at_last;
        err_now  = (i_s_axis_tlast ^ at_last) | (i_s_axis_tuser & (col_q != '0));
    end

    // Writes land one cycle after the read, so a beat hitting the address
    // written by the previous beat takes that write data from the bypass copy.
    always_comb begin
        eff_rd    = byp_q ? byp_data_q : ram_rd;
        ram_wd[0] = pix_q;
        for (int k = 1; k < NUM_LINEBUF; k++) ram_wd[k] = eff_rd[k-1];
        raw_col[0] = pix_q;
        for (int k = 1; k < NUM_ROWS; k++) raw_col[k] = eff_rd[k-1];
    end

    // Next-state for the column counter, fill counter and output stage.
    always_comb begin
        tready_d   = 1'b1;
        col_d      = col_q;
        fill_d     = fill_q;
        vld_d      = accept;
        pix_d      = pix_q;
        addr_d     = addr_q;
        ofill_d    = ofill_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        err_d      = accept & err_now;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (accept) begin
            col_d      = line_end ? '0 : col_eff + 1'b1;
            fill_d     = line_end ? fill_inc(fill_eff) : fill_eff;
            pix_d      = i_s_axis_tdata;
            addr_d     = col_eff;
            ofill_d    = fill_eff;
            sof_d      = i_s_axis_tuser;
            eol_d      = line_end;
            byp_d      = vld_q & (col_eff == addr_q);
            byp_data_d = ram_wd;
        end
    end

    // State registers; line buffer contents are deliberately left out of reset.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            tready_q   <= 1'b0;
            col_q      <= '0;
            fill_q     <= '0;
            vld_q      <= 1'b0;
            pix_q      <= '0;
            addr_q     <= '0;
            ofill_q    <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            err_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            tready_q   <= tready_d;
            col_q      <= col_d;
            fill_q     <= fill_d;
            vld_q      <= vld_d;
            pix_q      <= pix_d;
            addr_q     <= addr_d;
            ofill_q    <= ofill_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            err_q      <= err_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Rows above the lines filled so far in this frame are zeroed or replicated.
    always_comb begin
        for (int k = 0; k < NUM_ROWS; k++) begin
            if (FILL_W'(k) > ofill_q) out_col[k] = REPLICATE ? raw_col[ofill_q] : '0;
            else                      out_col[k] = raw_col[k];
        end
    end

    for (genvar g = 0; g < NUM_LINEBUF; g++) begin : g_lb
        line_buffer_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .AW         (AW)
        ) u_lb (
            .i_clk   (i_clk),
            .i_we    (vld_q),
            .i_waddr (addr_q),
            .i_wdata (ram_wd[g]),
            .i_re    (accept),
            .i_raddr (col_eff),
            .o_rdata (ram_rd[g])
        );
    end

    assign o_s_axis_tready = tready_q;
    assign o_col_0         = out_col[0];
    assign o_col_1         = out_col[1];
    assign o_col_2         = out_col[2];
    assign o_col_3         = out_col[3];
    assign o_col_4         = out_col[4];
    assign o_col_valid     = vld_q;
    assign o_col_sof       = sof_q;
    assign o_col_eol       = eol_q;
    assign o_rows_full     = (ofill_q == FILL_W'(NUM_LINEBUF));
    assign o_err_eol       = err_q;

endmodule
